// File: rtl/i2c_slave_if.sv
// Open-drain I2C pin bundle between a bus master (or its model) and the slave target.
interface i2c_slave_if;
  logic scl_in;
  logic sda_in;
  logic sda_oe;

  modport master (output scl_in, output sda_in, input sda_oe);
  modport slave  (input scl_in, input sda_in, output sda_oe);
endinterface

// File: rtl/i2c_slave_fsm.sv
// Oversampled I2C slave: decodes START/STOP and the address, receives two write bytes
// or returns two read bytes, all clocked by clk with scl/sda treated as sampled data.
module i2c_slave_fsm #(
  parameter int                  ADDR_LEN   = 7,
  parameter int                  DATA_LEN   = 8,
  parameter logic [ADDR_LEN-1:0] SLAVE_ADDR = 7'b1010110,
  parameter int                  NUM_BYTES  = 2
) (
  input  logic                clk,
  input  logic                rst,
  i2c_slave_if.slave          bus,
  input  logic [DATA_LEN-1:0] tx_data_1,
  input  logic [DATA_LEN-1:0] tx_data_2,
  output logic [DATA_LEN-1:0] rx_data_1,
  output logic [DATA_LEN-1:0] rx_data_2,
  output logic                rx_valid,
  output logic                rd_done,
  output logic                addr_hit,
  output logic                busy
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ADDR      = 3'd1;
  localparam logic [2:0] ADDR_ACK  = 3'd2;
  localparam logic [2:0] WR_DATA   = 3'd3;
  localparam logic [2:0] WR_ACK    = 3'd4;
  localparam logic [2:0] RD_DATA   = 3'd5;
  localparam logic [2:0] RD_ACK    = 3'd6;
  localparam logic [2:0] WAIT_STOP = 3'd7;

  localparam int SH_W  = (ADDR_LEN + 1 > DATA_LEN) ? ADDR_LEN + 1 : DATA_LEN;
  localparam int CNT_W = $clog2(SH_W + 1);
  localparam logic [CNT_W-1:0] ADDR_BITS = CNT_W'(ADDR_LEN + 1);
  localparam logic [CNT_W-1:0] DATA_BITS = CNT_W'(DATA_LEN);

  logic scl_p0, scl_p1, scl_p2;
  logic sda_p0, sda_p1, sda_p2;
  logic scl_rise, scl_fall, start_det, stop_det;

  logic [2:0]       state;
  logic [CNT_W-1:0] bit_cnt;
  logic [SH_W-1:0]  shift;
  logic             byte_idx;
  logic             rw;
  logic             rx_pend;
  logic             sda_drive;
  logic             more_bytes;
  logic [DATA_LEN-1:0] tx_shadow_2;

  // Stage p0/p1: two-flop synchronizer, p2: previous synced value for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_p0 <= 1'b1; scl_p1 <= 1'b1; scl_p2 <= 1'b1;
      sda_p0 <= 1'b1; sda_p1 <= 1'b1; sda_p2 <= 1'b1;
    end else begin
      scl_p0 <= bus.scl_in; scl_p1 <= scl_p0; scl_p2 <= scl_p1;
      sda_p0 <= bus.sda_in; sda_p1 <= sda_p0; sda_p2 <= sda_p1;
    end
  end

  assign scl_rise   = scl_p1 & ~scl_p2;
  assign scl_fall   = ~scl_p1 & scl_p2;
  assign start_det  = scl_p1 & ~sda_p1 & sda_p2;
  assign stop_det   = scl_p1 & sda_p1 & ~sda_p2;
  assign more_bytes = int'(byte_idx) < NUM_BYTES - 1;
  assign bus.sda_oe = sda_drive;

  // Stage p3: protocol FSM acting on the detected bus events
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shift       <= '0;
      byte_idx    <= 1'b0;
      rw          <= 1'b0;
      rx_pend     <= 1'b0;
      sda_drive   <= 1'b0;
      tx_shadow_2 <= '0;
      rx_data_1   <= '0;
      rx_data_2   <= '0;
      rx_valid    <= 1'b0;
      rd_done     <= 1'b0;
      addr_hit    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      rd_done  <= 1'b0;
      rx_pend  <= 1'b0;
      rx_valid <= rx_pend;
      if (stop_det) begin
        state     <= IDLE;
        busy      <= 1'b0;
        addr_hit  <= 1'b0;
        sda_drive <= 1'b0;
      end else if (start_det) begin
        state     <= ADDR;
        busy      <= 1'b1;
        bit_cnt   <= '0;
        addr_hit  <= 1'b0;
        sda_drive <= 1'b0;
      end else begin
        case (state)
          ADDR: begin
            if (scl_rise) begin
              shift   <= {shift[SH_W-2:0], sda_p1};
              bit_cnt <= bit_cnt + 1'b1;
            end else if (scl_fall && bit_cnt == ADDR_BITS) begin
              rw <= shift[0];
              if (shift[ADDR_LEN:1] == SLAVE_ADDR) begin
                sda_drive <= 1'b1;
                addr_hit  <= 1'b1;
                state     <= ADDR_ACK;
              end else begin
                sda_drive <= 1'b0;
                state     <= WAIT_STOP;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              byte_idx <= 1'b0;
              if (!rw) begin
                sda_drive <= 1'b0;
                bit_cnt   <= '0;
                state     <= WR_DATA;
              end else begin
                // MSB goes out now; the shifter holds the remaining bits left-aligned
                tx_shadow_2 <= tx_data_2;
                shift       <= SH_W'({tx_data_1[DATA_LEN-2:0], 1'b0});
                sda_drive   <= ~tx_data_1[DATA_LEN-1];
                bit_cnt     <= CNT_W'(1);
                state       <= RD_DATA;
              end
            end
          end
          WR_DATA: begin
            if (scl_rise) begin
              shift   <= {shift[SH_W-2:0], sda_p1};
              bit_cnt <= bit_cnt + 1'b1;
            end else if (scl_fall && bit_cnt == DATA_BITS) begin
              sda_drive <= 1'b1;
              state     <= WR_ACK;
              if (!byte_idx) begin
                rx_data_1 <= shift[DATA_LEN-1:0];
              end else begin
                rx_data_2 <= shift[DATA_LEN-1:0];
                rx_pend   <= 1'b1;
              end
            end
          end
          WR_ACK: begin
            if (scl_fall) begin
              sda_drive <= 1'b0;
              if (more_bytes) begin
                byte_idx <= 1'b1;
                bit_cnt  <= '0;
                state    <= WR_DATA;
              end else begin
                state <= WAIT_STOP;
              end
            end
          end
          RD_DATA: begin
            if (scl_fall) begin
              if (bit_cnt == DATA_BITS) begin
                sda_drive <= 1'b0;
                state     <= RD_ACK;
              end else begin
                sda_drive <= ~shift[DATA_LEN-1];
                shift     <= shift << 1;
                bit_cnt   <= bit_cnt + 1'b1;
              end
            end
          end
          RD_ACK: begin
            if (scl_rise && (sda_p1 || !more_bytes)) begin
              rd_done <= 1'b1;
              state   <= WAIT_STOP;
            end else if (scl_fall) begin
              byte_idx  <= 1'b1;
              shift     <= SH_W'({tx_shadow_2[DATA_LEN-2:0], 1'b0});
              sda_drive <= ~tx_shadow_2[DATA_LEN-1];
              bit_cnt   <= CNT_W'(1);
              state     <= RD_DATA;
            end
          end
          WAIT_STOP: sda_drive <= 1'b0;
          IDLE:      sda_drive <= 1'b0;
          default: begin
            sda_drive <= 1'b0;
            state     <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_fsm.sv
// Bench for i2c_slave_fsm: an open-drain bus master model with a byte scoreboard.
module tb_i2c_slave_fsm;
  localparam int Q = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       m_scl, m_sda;
  logic [7:0] tx1, tx2;
  logic [7:0] rx1, rx2;
  logic       rx_valid, rd_done, addr_hit, busy;

  int n_checks = 0;
  int n_pass   = 0;
  int oe_cnt   = 0;
  int rxv_cnt  = 0;
  int rdd_cnt  = 0;
  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];

  i2c_slave_if bus ();
  assign bus.scl_in = m_scl;
  assign bus.sda_in = m_sda & ~bus.sda_oe;

  i2c_slave_fsm dut (
    .clk(clk), .rst(rst), .bus(bus),
    .tx_data_1(tx1), .tx_data_2(tx2),
    .rx_data_1(rx1), .rx_data_2(rx2),
    .rx_valid(rx_valid), .rd_done(rd_done),
    .addr_hit(addr_hit), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.sda_oe) oe_cnt <= oe_cnt + 1;
    if (rd_done) rdd_cnt <= rdd_cnt + 1;
    if (rx_valid) begin
      rxv_cnt <= rxv_cnt + 1;
      obs_q.push_back({rx1, rx2});
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, output logic seen, output logic oe);
    wait_n(Q); m_sda = b;
    wait_n(Q); m_scl = 1'b1;
    wait_n(Q); seen = bus.sda_in; oe = bus.sda_oe;
    wait_n(Q); m_scl = 1'b0;
  endtask

  task automatic start_cond();
    m_sda = 1'b1; wait_n(Q);
    m_scl = 1'b1; wait_n(Q);
    m_sda = 1'b0; wait_n(Q);
    m_scl = 1'b0;
  endtask

  task automatic stop_cond();
    m_sda = 1'b0; wait_n(Q);
    m_scl = 1'b1; wait_n(Q);
    m_sda = 1'b1; wait_n(2 * Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s, o;
    for (int i = 7; i >= 0; i--) send_bit(b[i], s, o);
    send_bit(1'b1, ack, o);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] d);
    logic s, o;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, s, o);
      d[i] = s;
    end
    send_bit(~mack, s, o);
  endtask

  task automatic test_reset();
    rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1;
    wait_n(3);
    n_checks++;
    if ({bus.sda_oe, busy, addr_hit, rx_valid, rd_done} !== 5'b0)
      $display("FAIL reset_ctrl: got %b want 00000", {bus.sda_oe, busy, addr_hit, rx_valid, rd_done});
    else n_pass++;
    n_checks++;
    if ({rx1, rx2} !== 16'h0) $display("FAIL reset_rx: got %h want 0000", {rx1, rx2});
    else n_pass++;
    rst = 1'b0;
    wait_n(4);
  endtask

  task automatic test_write();
    logic ack;
    int rxv0;
    logic [15:0] got, want;
    rxv0 = rxv_cnt;
    start_cond();
    send_byte(8'hAC, ack);
    n_checks++;
    if (ack !== 1'b0) $display("FAIL wr_addr_ack: got %b want 0", ack); else n_pass++;
    n_checks++;
    if (addr_hit !== 1'b1) $display("FAIL wr_addr_hit: got %b want 1", addr_hit); else n_pass++;
    exp_q.push_back(16'hABEF);
    send_byte(8'hAB, ack);
    n_checks++;
    if (ack !== 1'b0) $display("FAIL wr_ack_b0: got %b want 0", ack); else n_pass++;
    send_byte(8'hEF, ack);
    n_checks++;
    if (ack !== 1'b0) $display("FAIL wr_ack_b1: got %b want 0", ack); else n_pass++;
    m_sda = 1'b0; wait_n(Q);
    m_scl = 1'b1; wait_n(Q);
    m_sda = 1'b1; wait_n(2);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL wr_busy_hold: got %b want 1", busy); else n_pass++;
    wait_n(1);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL wr_busy_drop: got %b want 0", busy); else n_pass++;
    wait_n(2 * Q);
    n_checks++;
    if (rxv_cnt - rxv0 !== 1) $display("FAIL wr_rx_valid_cnt: got %0d want 1", rxv_cnt - rxv0); else n_pass++;
    n_checks++;
    want = exp_q.pop_front();
    if (obs_q.size() == 0) $display("FAIL wr_data: got none want %h", want);
    else begin
      got = obs_q.pop_front();
      if (got !== want) $display("FAIL wr_data: got %h want %h", got, want); else n_pass++;
    end
  endtask

  task automatic test_mismatch();
    logic ack;
    int oe0, rxv0;
    logic [15:0] rx0;
    oe0 = oe_cnt; rxv0 = rxv_cnt; rx0 = {rx1, rx2};
    start_cond();
    send_byte(8'hAE, ack);
    n_checks++;
    if (ack !== 1'b1) $display("FAIL mm_addr_nack: got %b want 1", ack); else n_pass++;
    n_checks++;
    if (addr_hit !== 1'b0) $display("FAIL mm_addr_hit: got %b want 0", addr_hit); else n_pass++;
    send_byte(8'hAB, ack);
    send_byte(8'hEF, ack);
    stop_cond();
    n_checks++;
    if (oe_cnt - oe0 !== 0) $display("FAIL mm_oe_cycles: got %0d want 0", oe_cnt - oe0); else n_pass++;
    n_checks++;
    if (rxv_cnt - rxv0 !== 0) $display("FAIL mm_rx_valid: got %0d want 0", rxv_cnt - rxv0); else n_pass++;
    n_checks++;
    if ({rx1, rx2} !== rx0) $display("FAIL mm_rx_hold: got %h want %h", {rx1, rx2}, rx0); else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL mm_idle: got busy %b want 0", busy); else n_pass++;
  endtask

  task automatic test_read();
    logic ack;
    logic [7:0] d;
    logic [15:0] want;
    int rdd0;
    rdd0 = rdd_cnt;
    tx1 = 8'h3C; tx2 = 8'hA5;
    exp_q.push_back(16'h003C);
    exp_q.push_back(16'h00A5);
    start_cond();
    send_byte(8'hAD, ack);
    n_checks++;
    if (ack !== 1'b0) $display("FAIL rd_addr_ack: got %b want 0", ack); else n_pass++;
    recv_byte(1'b1, d);
    want = exp_q.pop_front();
    n_checks++;
    if ({8'h00, d} !== want) $display("FAIL rd_byte0: got %h want %h", d, want[7:0]); else n_pass++;
    recv_byte(1'b0, d);
    want = exp_q.pop_front();
    n_checks++;
    if ({8'h00, d} !== want) $display("FAIL rd_byte1: got %h want %h", d, want[7:0]); else n_pass++;
    n_checks++;
    if (rdd_cnt - rdd0 !== 1) $display("FAIL rd_done_cnt: got %0d want 1", rdd_cnt - rdd0); else n_pass++;
    n_checks++;
    if (bus.sda_oe !== 1'b0) $display("FAIL rd_release: got %b want 0", bus.sda_oe); else n_pass++;
    stop_cond();
    n_checks++;
    if (busy !== 1'b0) $display("FAIL rd_idle: got busy %b want 0", busy); else n_pass++;
  endtask

  task automatic test_early_nack();
    logic ack;
    logic [7:0] d;
    logic [15:0] want;
    int rdd0, oe0;
    rdd0 = rdd_cnt;
    tx1 = 8'h3C; tx2 = 8'hA5;
    exp_q.push_back(16'h003C);
    start_cond();
    send_byte(8'hAD, ack);
    recv_byte(1'b0, d);
    want = exp_q.pop_front();
    n_checks++;
    if ({8'h00, d} !== want) $display("FAIL en_byte0: got %h want %h", d, want[7:0]); else n_pass++;
    n_checks++;
    if (rdd_cnt - rdd0 !== 1) $display("FAIL en_rd_done: got %0d want 1", rdd_cnt - rdd0); else n_pass++;
    oe0 = oe_cnt;
    recv_byte(1'b0, d);
    n_checks++;
    if (oe_cnt - oe0 !== 0) $display("FAIL en_no_byte1: got %0d oe cycles want 0", oe_cnt - oe0); else n_pass++;
    stop_cond();
  endtask

  task automatic test_rep_start();
    logic ack, s, o;
    int rxv0;
    logic [15:0] got, want;
    rxv0 = rxv_cnt;
    start_cond();
    send_byte(8'hAC, ack);
    send_bit(1'b0, s, o); send_bit(1'b0, s, o);
    send_bit(1'b0, s, o); send_bit(1'b1, s, o);
    start_cond();
    send_byte(8'hAC, ack);
    n_checks++;
    if (ack !== 1'b0) $display("FAIL rs_addr_ack: got %b want 0", ack); else n_pass++;
    exp_q.push_back(16'h5A96);
    send_byte(8'h5A, ack);
    send_byte(8'h96, ack);
    stop_cond();
    n_checks++;
    if (rxv_cnt - rxv0 !== 1) $display("FAIL rs_rx_valid_cnt: got %0d want 1", rxv_cnt - rxv0); else n_pass++;
    n_checks++;
    want = exp_q.pop_front();
    if (obs_q.size() == 0) $display("FAIL rs_data: got none want %h", want);
    else begin
      got = obs_q.pop_front();
      if (got !== want) $display("FAIL rs_data: got %h want %h", got, want); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic ack, s, o;
    logic [7:0] a;
    int oe0;
    a = 8'hAC;
    start_cond();
    for (int i = 7; i >= 0; i--) send_bit(a[i], s, o);
    wait_n(Q); m_sda = 1'b1;
    wait_n(Q); m_scl = 1'b1;
    wait_n(Q);
    n_checks++;
    if (bus.sda_oe !== 1'b1) $display("FAIL rm_ack_drive: got %b want 1", bus.sda_oe); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.sda_oe, busy, addr_hit} !== 3'b000)
      $display("FAIL rm_async_clear: got %b want 000", {bus.sda_oe, busy, addr_hit});
    else n_pass++;
    wait_n(Q);
    rst = 1'b0;
    m_scl = 1'b0;
    oe0 = oe_cnt;
    send_byte(8'hAC, ack);
    n_checks++;
    if (ack !== 1'b1) $display("FAIL rm_ignore_ack: got %b want 1", ack); else n_pass++;
    n_checks++;
    if ((oe_cnt - oe0 !== 0) || (busy !== 1'b0))
      $display("FAIL rm_ignore: got oe %0d busy %b want 0 0", oe_cnt - oe0, busy);
    else n_pass++;
    stop_cond();
  endtask

  initial begin
    tx1 = 8'h00; tx2 = 8'h00;
    test_reset();
    test_write();
    test_mismatch();
    test_read();
    test_early_nack();
    test_rep_start();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
